// File: rtl/avalon_burst_rr_arbiter.sv
// Round-robin per-slave arbiter for the Avalon crossbar; holds the grant across bursts.
// Define XBAR_ARB_LOCK_EN to add i_In_Lock and re-grant a locked holder at release.
module avalon_burst_rr_arbiter #(
    parameter int unsigned NUM_INPUTS = 5,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned BURST_W    = 8
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset,
    input  logic [NUM_INPUTS-1:0]         i_In_Req,
    input  logic [NUM_INPUTS-1:0]         i_In_Read,
    input  logic [NUM_INPUTS-1:0]         i_In_Write,
    input  logic [NUM_INPUTS*BURST_W-1:0] i_In_BurstCount,
`ifdef XBAR_ARB_LOCK_EN
    input  logic [NUM_INPUTS-1:0]         i_In_Lock,
`endif
    input  logic                          i_Out_WaitRequest,
    input  logic                          i_Out_ReadDataValid,
    output logic [SEL_W-1:0]              o_MuxSel,
    output logic [NUM_INPUTS-1:0]         o_Grant,
    output logic                          o_Grant_Valid,
    output logic                          o_Protocol_Err
);

    typedef enum logic [1:0] {StIdle, StCmd, StWrBurst, StRdWait} state_e;

    state_e                  state_q, state_d;
    logic [BURST_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]        ptr_q, ptr_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [NUM_INPUTS-1:0]   grant_q, grant_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;

    logic                    g_req, g_read, g_rw, accepted, foreign_acc;
    logic [BURST_W-1:0]      g_bc, eff_len;
    logic [NUM_INPUTS-1:0]   req_mask;
    logic                    win_found;
    logic [SEL_W-1:0]        win_idx;
    logic                    release_now, relock, new_grant;
    int                      idx;

    // Granted-master view of the request/command inputs
    always_comb begin
        g_req    = |(i_In_Req & grant_q);
        g_read   = |(i_In_Read & grant_q);
        g_rw     = |((i_In_Read | i_In_Write) & grant_q);
        accepted = g_rw & ~i_Out_WaitRequest;
        foreign_acc = (|((i_In_Read | i_In_Write) & ~grant_q)) & ~i_Out_WaitRequest;
        g_bc = '0;
        for (int k = 0; k < int'(NUM_INPUTS); k++) begin
            if (grant_q[k]) g_bc = i_In_BurstCount[k*BURST_W +: BURST_W];
        end
        eff_len = (g_bc == '0) ? BURST_W'(1) : g_bc;
    end

`ifdef XBAR_ARB_LOCK_EN
    assign relock = |(i_In_Lock & i_In_Req & grant_q);
`else
    assign relock = 1'b0;
`endif

    // Round-robin search from ptr+1; the current holder is excluded at release
    always_comb begin
        req_mask  = (state_q == StIdle) ? i_In_Req : (i_In_Req & ~grant_q);
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 1; i <= int'(NUM_INPUTS); i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= int'(NUM_INPUTS)) idx = idx - int'(NUM_INPUTS);
            if (!win_found && (|(req_mask & (NUM_INPUTS'(1) << idx)))) begin
                win_found = 1'b1;
                win_idx   = SEL_W'(idx);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= SEL_W'(NUM_INPUTS - 1);
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        release_now = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) state_d = StCmd;
            end
            StCmd: begin
                if (accepted) begin
                    if (g_read) begin
                        cnt_d   = eff_len;
                        state_d = StRdWait;
                    end else if (eff_len == BURST_W'(1)) begin
                        release_now = 1'b1;
                    end else begin
                        cnt_d   = eff_len - BURST_W'(1);
                        state_d = StWrBurst;
                    end
                end else if (!g_req) begin
                    release_now = 1'b1;
                end
            end
            StWrBurst: begin
                if (accepted) begin
                    if (cnt_q == BURST_W'(1)) release_now = 1'b1;
                    else cnt_d = cnt_q - BURST_W'(1);
                end
            end
            StRdWait: begin
                if (i_Out_ReadDataValid) begin
                    if (cnt_q == BURST_W'(1)) release_now = 1'b1;
                    else cnt_d = cnt_q - BURST_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (release_now) state_d = (relock || win_found) ? StCmd : StIdle;
    end

    // Next values of the registered outputs; a relock keeps everything as is
    always_comb begin
        grant_d   = grant_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        ptr_d     = ptr_q;
        new_grant = win_found && ((state_q == StIdle) || (release_now && !relock));
        if (new_grant) begin
            grant_d = NUM_INPUTS'(1) << win_idx;
            sel_d   = win_idx;
            valid_d = 1'b1;
            ptr_d   = win_idx;
        end else if (release_now && !relock) begin
            grant_d = '0;
            sel_d   = '0;
            valid_d = 1'b0;
        end
        err_d = err_q | (i_Out_ReadDataValid && (state_q != StRdWait)) | foreign_acc;
    end

    assign o_MuxSel       = sel_q;
    assign o_Grant        = grant_q;
    assign o_Grant_Valid  = valid_q;
    assign o_Protocol_Err = err_q;

endmodule

// File: tb/tb_avalon_burst_rr_arbiter.sv
// Directed bench for avalon_burst_rr_arbiter: vector table plus hand sequences.
module tb_avalon_burst_rr_arbiter;

    localparam int N  = 5;
    localparam int SW = 3;
    localparam int BW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, rd, wr;
    logic [N*BW-1:0] bc;
    logic            wt, rdv;
    logic [SW-1:0]   sel;
    logic [N-1:0]    grant;
    logic            gvalid, perr;
`ifdef XBAR_ARB_LOCK_EN
    logic [N-1:0]    lock;
`endif

    avalon_burst_rr_arbiter #(.NUM_INPUTS(N), .SEL_W(SW), .BURST_W(BW)) dut (
        .i_Clk               (clk),
        .i_Reset             (rst),
        .i_In_Req            (req),
        .i_In_Read           (rd),
        .i_In_Write          (wr),
        .i_In_BurstCount     (bc),
`ifdef XBAR_ARB_LOCK_EN
        .i_In_Lock           (lock),
`endif
        .i_Out_WaitRequest   (wt),
        .i_Out_ReadDataValid (rdv),
        .o_MuxSel            (sel),
        .o_Grant             (grant),
        .o_Grant_Valid       (gvalid),
        .o_Protocol_Err      (perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic [N-1:0]    req, rd, wr;
        logic [N*BW-1:0] bc;
        logic            wt, rdv;
        logic [N-1:0]    eg;
        logic [SW-1:0]   es;
        logic            ev, ee;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [N-1:0] eg, input logic [SW-1:0] es,
                             input logic ev, input logic ee);
        chk({tag, " grant"}, 32'(grant), 32'(eg));
        chk({tag, " sel"}, 32'(sel), 32'(es));
        chk({tag, " valid"}, 32'(gvalid), 32'(ev));
        chk({tag, " err"}, 32'(perr), 32'(ee));
    endtask

    function automatic logic [N*BW-1:0] bcv(input int m, input int len);
        logic [N*BW-1:0] v;
        v = '0;
        v[m*BW +: BW] = BW'(len);
        return v;
    endfunction

    task automatic add(input logic r, input logic [N-1:0] q, input logic [N-1:0] rdi,
                       input logic [N-1:0] wri, input logic [N*BW-1:0] b, input logic w,
                       input logic dv, input logic [N-1:0] eg, input logic [SW-1:0] es,
                       input logic ev, input logic ee);
        vec_t v;
        v.rst = r; v.req = q; v.rd = rdi; v.wr = wri; v.bc = b; v.wt = w; v.rdv = dv;
        v.eg = eg; v.es = es; v.ev = ev; v.ee = ee;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        req = '0; rd = '0; wr = '0; bc = '0; wt = 1'b0; rdv = 1'b0;
`ifdef XBAR_ARB_LOCK_EN
        lock = '0;
`endif
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();

        // rst req rd wr bc wait rdv | grant sel valid err
        // Single write from master 2
        add(1, 5'b00000, 0, 5'b00000, '0, 0, 0, 5'b00000, 0, 0, 0);
        add(0, 5'b00100, 0, 5'b00000, '0, 0, 0, 5'b00100, 2, 1, 0);
        add(0, 5'b00100, 0, 5'b00100, bcv(2, 1), 0, 0, 5'b00000, 0, 0, 0);
        add(0, 5'b00000, 0, 5'b00000, '0, 0, 0, 5'b00000, 0, 0, 0);
        // All masters requesting, single-beat writes (burstcount 0 = 1 beat)
        add(1, 5'b00000, 0, 5'b00000, '0, 0, 0, 5'b00000, 0, 0, 0);
        add(0, 5'b11111, 0, 5'b00000, '0, 0, 0, 5'b00001, 0, 1, 0);
        add(0, 5'b11111, 0, 5'b00001, '0, 0, 0, 5'b00010, 1, 1, 0);
        add(0, 5'b11111, 0, 5'b00010, '0, 0, 0, 5'b00100, 2, 1, 0);
        add(0, 5'b11111, 0, 5'b00100, '0, 0, 0, 5'b01000, 3, 1, 0);
        add(0, 5'b11111, 0, 5'b01000, '0, 0, 0, 5'b10000, 4, 1, 0);
        add(0, 5'b11111, 0, 5'b10000, '0, 0, 0, 5'b00001, 0, 1, 0);
        // Master 1 burst of 4 with a 3-cycle stall on beat 2, master 3 waiting
        add(1, 5'b00000, 0, 5'b00000, '0, 0, 0, 5'b00000, 0, 0, 0);
        add(0, 5'b01010, 0, 5'b00000, '0, 0, 0, 5'b00010, 1, 1, 0);
        add(0, 5'b01010, 0, 5'b00010, bcv(1, 4), 0, 0, 5'b00010, 1, 1, 0);
        add(0, 5'b01010, 0, 5'b00010, bcv(1, 4), 1, 0, 5'b00010, 1, 1, 0);
        add(0, 5'b01010, 0, 5'b00010, bcv(1, 4), 1, 0, 5'b00010, 1, 1, 0);
        add(0, 5'b01010, 0, 5'b00010, bcv(1, 4), 1, 0, 5'b00010, 1, 1, 0);
        add(0, 5'b01010, 0, 5'b00010, bcv(1, 4), 0, 0, 5'b00010, 1, 1, 0);
        add(0, 5'b01010, 0, 5'b00010, bcv(1, 4), 0, 0, 5'b00010, 1, 1, 0);
        add(0, 5'b01010, 0, 5'b00010, bcv(1, 4), 0, 0, 5'b01000, 3, 1, 0);
        // Master 3 abandons its request before any acceptance
        add(0, 5'b00000, 0, 5'b00000, '0, 0, 0, 5'b00000, 0, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; req = vecs[i].req; rd = vecs[i].rd; wr = vecs[i].wr;
            bc = vecs[i].bc; wt = vecs[i].wt; rdv = vecs[i].rdv;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].eg, vecs[i].es, vecs[i].ev, vecs[i].ee);
        end
        rst = 1'b0;
        idle_inputs();

        // Read burst of 8 from master 0 with gaps between readdatavalid beats
        rst = 1'b1; step(); rst = 1'b0;
        req = 5'b00001; step();
        check_out("rd8 grant", 5'b00001, 0, 1, 0);
        rd = 5'b00001; bc = bcv(0, 8); step();
        rd = '0; req = '0; bc = '0;
        for (int i = 0; i < 8; i++) begin
            rdv = 1'b1; step();
            if (i < 7) check_out($sformatf("rd8 beat%0d", i), 5'b00001, 0, 1, 0);
            else check_out("rd8 last", 5'b00000, 0, 0, 0);
            rdv = 1'b0; step();
            if (i < 7) check_out($sformatf("rd8 gap%0d", i), 5'b00001, 0, 1, 0);
            else check_out("rd8 idle", 5'b00000, 0, 0, 0);
        end

        // Burstcount 0 read completes on one readdatavalid
        req = 5'b00001; step();
        check_out("rd0 grant", 5'b00001, 0, 1, 0);
        rd = 5'b00001; step();
        check_out("rd0 cmd", 5'b00001, 0, 1, 0);
        rd = '0; req = '0; rdv = 1'b1; step();
        check_out("rd0 done", 5'b00000, 0, 0, 0);
        rdv = 1'b0;

        // Stray readdatavalid in idle sets a sticky error
        rdv = 1'b1; step();
        check_out("err set", 5'b00000, 0, 0, 1);
        rdv = 1'b0; step(); step();
        check_out("err sticky", 5'b00000, 0, 0, 1);
        rst = 1'b1; step(); rst = 1'b0;
        check_out("err clr", 5'b00000, 0, 0, 0);

        // Reset in the middle of a write burst restores the pointer too
        req = 5'b00100; step();
        check_out("mid grant", 5'b00100, 2, 1, 0);
        wr = 5'b00100; bc = bcv(2, 4); step();
        wr = '0; bc = '0; rst = 1'b1; step(); rst = 1'b0;
        check_out("mid reset", 5'b00000, 0, 0, 0);
        req = 5'b00101; step();
        check_out("mid regrant", 5'b00001, 0, 1, 0);
        req = '0; step();
        check_out("mid idle", 5'b00000, 0, 0, 0);

`ifdef XBAR_ARB_LOCK_EN
        // Locked master 2 keeps the grant for three transactions while master 4 waits
        rst = 1'b1; step(); rst = 1'b0;
        req = 5'b10100; lock = 5'b00100; step();
        check_out("lock grant", 5'b00100, 2, 1, 0);
        for (int t = 0; t < 3; t++) begin
            wr = 5'b00100;
            if (t == 2) lock = '0;
            step();
            if (t < 2) check_out($sformatf("lock hold%0d", t), 5'b00100, 2, 1, 0);
            else check_out("lock drop", 5'b10000, 4, 1, 0);
        end
        wr = '0; req = '0; step();
        check_out("lock idle", 5'b00000, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
